// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling and mid-bit vote points.
package uart_pkg;

  localparam int RX_DATA_BITS  = 8;
  localparam int RX_OVERSAMPLE = 16;
  localparam int VOTE_LO       = RX_OVERSAMPLE / 2 - 1;
  localparam int VOTE_MID      = RX_OVERSAMPLE / 2;
  localparam int VOTE_HI       = RX_OVERSAMPLE / 2 + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receive-side bundle: tick and serial line in, byte/strobes/busy out.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);

    logic                 tick_16x;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output tick_16x, rx_in,
        input  rx_data, rx_valid, frame_err, busy
    );

    modport slave (
        input  tick_16x, rx_in,
        output rx_data, rx_valid, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_bit_voter.sv
// Captures the synced line at the two early vote points; majority uses the live third sample.
module rx_bit_voter
    import uart_pkg::*;
#(
    parameter int SW       = 4,
    parameter int LO_POINT = VOTE_LO,
    parameter int MID_POINT = VOTE_MID
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          clr,
    input  logic [SW-1:0] s,
    input  logic          line,
    output logic          decision
);

    localparam logic [SW-1:0] S_LO  = SW'(LO_POINT);
    localparam logic [SW-1:0] S_MID = SW'(MID_POINT);

    logic v_lo, v_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_lo  <= 1'b1;
            v_mid <= 1'b1;
        end else if (clr) begin
            v_lo  <= 1'b1;
            v_mid <= 1'b1;
        end else if (tick) begin
            if (s == S_LO)  v_lo  <= line;
            if (s == S_MID) v_mid <= line;
        end
    end

    // Only meaningful on the tick at the last vote point; the caller qualifies it.
    assign decision = maj3(v_lo, v_mid, line);

endmodule

// File: rtl/uart_rx_sampler.sv
// 16x-oversampled 8N1 receiver front-end; all state advances on tick_16x enables in the CLOCK_50 domain.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = RX_DATA_BITS,
    parameter int OVERSAMPLE = RX_OVERSAMPLE
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    uart_rx_sampler_if.slave   bus
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [1:0]           sync_q;
    logic                 line;
    logic                 decision;
    logic                 at_vote, at_last, voter_clr;

    // Idle-high synchronizer; only sync_q[1] is ever looked at.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], bus.rx_in};
    end
    assign line = sync_q[1];

    assign at_vote   = (s_q == S_HI);
    assign at_last   = (s_q == S_LAST);
    assign voter_clr = (bus.tick_16x && at_last) || (state_q == IDLE);

    rx_bit_voter #(
        .SW        (SW),
        .LO_POINT  (OVERSAMPLE / 2 - 1),
        .MID_POINT (OVERSAMPLE / 2)
    ) u_voter (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .tick     (bus.tick_16x),
        .clr      (voter_clr),
        .s        (s_q),
        .line     (line),
        .decision (decision)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (bus.tick_16x) begin
            s_d = at_last ? '0 : s_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    s_d = '0;
                    // The detecting tick itself counts as s=0.
                    if (!line) begin
                        state_d = START;
                        s_d     = S_ONE;
                    end
                end
                START: begin
                    if (at_vote && decision) begin
                        state_d = IDLE;
                        s_d     = '0;
                    end else if (at_last) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (at_vote) shift_d = {decision, shift_q[DATA_BITS-1:1]};
                    if (at_last) begin
                        if (bit_q == B_LAST) state_d = STOP;
                        else                 bit_d   = bit_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at the vote so a back-to-back start edge is caught in time.
                    if (at_vote) begin
                        s_d = '0;
                        if (decision) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    s_d = '0;
                    if (line) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench: expected frames queued as they are driven, popped on each rx_valid/frame_err strobe.
module tb_uart_rx_sampler;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    uart_rx_sampler_if #(.DATA_BITS(8)) bus();

    uart_rx_sampler dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    int         n_chk = 0, n_err = 0, n_valid = 0, n_ferr = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Tick high for one clock in every four; changes land 1ns after an edge.
    initial begin
        bus.tick_16x = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 bus.tick_16x = 1'b1;
            @(posedge clk);
            #1 bus.tick_16x = 1'b0;
        end
    end

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
                continue;
            end
            if (bus.rx_valid || bus.frame_err) begin
                if (bus.rx_valid)  n_valid++;
                if (bus.frame_err) n_ferr++;
                chk("excl", 32'(bus.rx_valid & bus.frame_err), 0);
                chk("width", 32'(prev), 0);
                if (q.size() == 0) begin
                    chk("unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("kind", 32'(bus.frame_err), 32'(e.err));
                    chk("data", 32'(bus.rx_data), 32'(e.data));
                end
            end
            prev = bus.rx_valid | bus.frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic align();
        do @(posedge clk); while (bus.tick_16x !== 1'b1);
    endtask

    task automatic drive_bit(input logic b, input bit glitch);
        for (int c = 0; c < 64; c++) begin
            #1 bus.rx_in = (glitch && c >= 32 && c < 36) ? 1'b0 : b;
            @(posedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int gbit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], gbit == i);
        drive_bit(stop, 1'b0);
    endtask

    task automatic expect_good(input logic [7:0] d);
        q.push_back('{1'b0, d});
        last_good = d;
    endtask

    task automatic expect_err();
        q.push_back('{1'b1, last_good});
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        bus.rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data",  32'(bus.rx_data),   0);
        chk("rst_valid", 32'(bus.rx_valid),  0);
        chk("rst_ferr",  32'(bus.frame_err), 0);
        chk("rst_busy",  32'(bus.busy),      0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk);

        // 1: single good frame
        align();
        expect_good(8'hA5);
        send_byte(8'hA5, 1'b1, -1);
        drain("t1_drain");

        // 2: back-to-back frames, no idle gap
        align();
        expect_good(8'h00);
        expect_good(8'hFF);
        send_byte(8'h00, 1'b1, -1);
        send_byte(8'hFF, 1'b1, -1);
        drain("t2_drain");

        // 3: one-tick low glitch is a false start
        expect_good(8'hA5);
        q.delete();
        last_good = 8'hFF;
        align();
        for (int c = 0; c < 8; c++) begin
            #1 bus.rx_in = (c < 4) ? 1'b0 : 1'b1;
            @(posedge clk);
        end
        #1 chk("t3_busy_hi", 32'(bus.busy), 1);
        repeat (64) @(posedge clk);
        #1 chk("t3_busy_lo", 32'(bus.busy), 0);

        // 4: stop bit low, line held low, then a good frame
        last_good = 8'hFF;
        align();
        expect_err();
        send_byte(8'h3C, 1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        #1 chk("t4_busy_brk", 32'(bus.busy), 1);
        chk("t4_data_kept", 32'(bus.rx_data), 32'(8'hFF));
        drive_bit(1'b1, 1'b0);
        #1 chk("t4_busy_idle", 32'(bus.busy), 0);
        expect_good(8'h55);
        send_byte(8'h55, 1'b1, -1);
        drain("t4_drain");

        // 5: reset during bit 4 of 0x81
        align();
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            #1 bus.rx_in = 1'b0;
            @(posedge clk);
        end
        #1 chk("t5_busy_pre", 32'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_data", 32'(bus.rx_data), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_valid", 32'(bus.rx_valid), 0);
        last_good = 8'h00;
        bus.rx_in = 1'b1;
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        align();
        expect_good(8'h42);
        send_byte(8'h42, 1'b1, -1);
        drain("t5_drain");

        // 6: single-tick low glitch at mid-bit of a 1 data bit
        align();
        expect_good(8'hFF);
        send_byte(8'hFF, 1'b1, 3);
        drain("t6_drain");

        repeat (20) @(posedge clk);
        chk("n_valid", n_valid, 6);
        chk("n_ferr", n_ferr, 1);
        chk("q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
